// File: rtl/alu_seq_pkg.sv
// Shared opcodes, widths and helpers for the ALU command sequencer.
package alu_seq_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned OP_W           = 4;
  localparam int unsigned TAG_W_DEF      = 4;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  localparam logic [OP_W-1:0] OP_ADD       = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB       = 4'd1;
  localparam logic [OP_W-1:0] OP_AND       = 4'd2;
  localparam logic [OP_W-1:0] OP_OR        = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR       = 4'd4;
  localparam logic [OP_W-1:0] OP_SLL       = 4'd5;
  localparam logic [OP_W-1:0] OP_SRL       = 4'd6;
  localparam logic [OP_W-1:0] OP_MAX_LEGAL = 4'd6;

  // Response entry: {result, zero, illegal, tag}
  function automatic int unsigned rsp_entry_w(input int unsigned tag_w);
    return DATA_W + 1 + 1 + tag_w;
  endfunction

  function automatic logic is_illegal(input logic [OP_W-1:0] op);
    return op > OP_MAX_LEGAL;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU and response signal bundle for the ALU command sequencer.
interface alu_cmd_sequencer_if
  import alu_seq_pkg::*;
#(
  parameter int unsigned TAG_W = 4
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [OP_W-1:0]   cmd_op;
  logic [TAG_W-1:0]  cmd_tag;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_illegal;
  logic [TAG_W-1:0]  rsp_tag;

  logic [31:0]       stat_done;
  logic [31:0]       stat_zero;

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
    output cmd_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result, alu_zero,
    output rsp_valid, rsp_result, rsp_zero, rsp_illegal, rsp_tag,
    input  rsp_ready,
    output stat_done, stat_zero
  );

  // Command producer / ALU / response consumer side
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
    input  cmd_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result, alu_zero,
    input  rsp_valid, rsp_result, rsp_zero, rsp_illegal, rsp_tag,
    output rsp_ready,
    input  stat_done, stat_zero
  );

endinterface

// File: rtl/alu_seq_fifo.sv
// Synchronous FIFO with async active-high reset; DEPTH must be a power of two.
module alu_seq_fifo #(
  parameter int unsigned WIDTH = 38,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head_c,
  output logic                   o_full_c,
  output logic                   o_empty_c,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full_c  = (r_count == CNT_W'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_count   = r_count;
  assign o_head_c  = r_mem[r_rd_ptr];

  // A full FIFO still accepts a push when the head leaves on the same edge
  assign w_do_pop  = i_pop && !o_empty_c;
  assign w_do_push = i_push && (!o_full_c || w_do_pop);

  // Storage and write pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
      r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
    end
  end

  // Read pointer and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue/collect stage around an external combinational ALU: registers
// operands onto the ALU, captures the result a cycle later into a response
// FIFO, returns tagged responses in order.
// Optional statistics counters: define ALU_CMD_SEQ_STATS_EN.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  alu_cmd_sequencer_if.slave  bus
);

  localparam int unsigned ENTRY_W = rsp_entry_w(TAG_W);
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

  logic              r_s1_valid;
  logic              r_s1_illegal;
  logic [TAG_W-1:0]  r_s1_tag;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [OP_W-1:0]   r_alu_op;

  logic              w_cmd_ready;
  logic              w_accept;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [ENTRY_W-1:0] w_push_data;
  logic [ENTRY_W-1:0] w_head;

  // Credit check from registers only: S1 always owns a reserved FIFO slot
  assign w_cmd_ready = (w_count + CNT_W'(r_s1_valid)) < CNT_W'(FIFO_DEPTH);
  assign w_accept    = bus.cmd_valid && w_cmd_ready;
  assign w_pop       = bus.rsp_valid && bus.rsp_ready;

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_op    = r_alu_op;

  // Issue stage: operands hold their last value while S1 is idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_illegal <= 1'b0;
      r_s1_tag     <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_alu_a      <= bus.cmd_a;
        r_alu_b      <= bus.cmd_b;
        r_alu_op     <= bus.cmd_op;
        r_s1_tag     <= bus.cmd_tag;
        r_s1_illegal <= is_illegal(bus.cmd_op);
      end
    end
  end

  assign w_push_data = {bus.alu_result, bus.alu_zero, r_s1_illegal, r_s1_tag};

  alu_seq_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (r_s1_valid),
    .i_data    (w_push_data),
    .i_pop     (w_pop),
    .o_head_c  (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_count   (w_count)
  );

  assign bus.rsp_valid = !w_empty;
  assign {bus.rsp_result, bus.rsp_zero, bus.rsp_illegal, bus.rsp_tag} = w_head;

  // Capture never finds the FIFO full unless the head leaves on that edge
  a_s1_has_slot: assert property (@(posedge clk) disable iff (rst)
    (r_s1_valid && w_full) |-> w_pop);

`ifdef ALU_CMD_SEQ_STATS_EN
  logic [31:0] r_stat_done;
  logic [31:0] r_stat_zero;

  // Completed and zero-result response counters, wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_done <= '0;
      r_stat_zero <= '0;
    end else if (w_pop) begin
      r_stat_done <= r_stat_done + 32'd1;
      if (bus.rsp_zero) r_stat_zero <= r_stat_zero + 32'd1;
    end
  end

  assign bus.stat_done = r_stat_done;
  assign bus.stat_zero = r_stat_zero;
`else
  assign bus.stat_done = 32'd0;
  assign bus.stat_zero = 32'd0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with an in-bench ALU and a
// response scoreboard.
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  localparam int unsigned TAG_W      = 4;
  localparam int unsigned FIFO_DEPTH = 4;

  typedef struct packed {
    logic [31:0]      res;
    logic             zero;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.TAG_W(TAG_W)) bus ();

  alu_cmd_sequencer #(
    .TAG_W      (TAG_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  // External ALU model
  assign bus.alu_result = alu_f(bus.alu_a, bus.alu_b, bus.alu_op);
  assign bus.alu_zero   = (bus.alu_result == 32'd0);

  int   checks = 0;
  int   errors = 0;
  int   n_acc  = 0;
  int   cyc    = 0;
  exp_t q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: compare popped heads, record accepted commands
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        check("rsp_expected", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          check("rsp_result",  64'(bus.rsp_result),  64'(e.res));
          check("rsp_zero",    64'(bus.rsp_zero),    64'(e.zero));
          check("rsp_illegal", 64'(bus.rsp_illegal), 64'(e.ill));
          check("rsp_tag",     64'(bus.rsp_tag),     64'(e.tag));
        end
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        exp_t n;
        n.res  = alu_f(bus.cmd_a, bus.cmd_b, bus.cmd_op);
        n.zero = (n.res == 32'd0);
        n.ill  = (bus.cmd_op > 4'd6);
        n.tag  = bus.cmd_tag;
        q.push_back(n);
        n_acc++;
      end
    end
  end

  // Hold cmd_valid until the command is taken; returns at posedge+1
  task automatic wait_accept();
    bit ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    check("cmd_accepted", 64'(ok), 64'd1);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [TAG_W-1:0] tag);
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = op;
    bus.cmd_tag   = tag;
    bus.cmd_valid = 1'b1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op, input logic [TAG_W-1:0] tag);
    drive(a, b, op, tag);
    wait_accept();
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Single command into an empty pipe, head checked one edge after accept
  task automatic txn(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] op, input logic [TAG_W-1:0] tag,
                     input logic [31:0] eres, input logic ezero, input logic eill);
    send(a, b, op, tag);
    bus.cmd_valid = 1'b0;
    check({name, "_lat_not_yet"}, 64'(bus.rsp_valid), 64'd0);
    @(posedge clk); #1;
    check({name, "_valid"},   64'(bus.rsp_valid),   64'd1);
    check({name, "_result"},  64'(bus.rsp_result),  64'(eres));
    check({name, "_zero"},    64'(bus.rsp_zero),    64'(ezero));
    check({name, "_illegal"}, 64'(bus.rsp_illegal), 64'(eill));
    check({name, "_tag"},     64'(bus.rsp_tag),     64'(tag));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int c0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_op    = '0;
    bus.cmd_tag   = '0;
    bus.rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("rst_alu_a",     64'(bus.alu_a),     64'd0);
    check("rst_alu_op",    64'(bus.alu_op),    64'd0);
    check("rst_stat_done", 64'(bus.stat_done), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;

    // Directed single transactions
    txn("add", 32'd5, 32'd7, OP_ADD, 4'd3, 32'd12, 1'b0, 1'b0);
    check("alu_a_hold", 64'(bus.alu_a), 64'd5);
    txn("sub", 32'd9, 32'd9, OP_SUB, 4'd1, 32'd0, 1'b1, 1'b0);
    txn("srl", 32'h8000_0000, 32'd31, OP_SRL, 4'd2, 32'd1, 1'b0, 1'b0);
    txn("ill", 32'd1, 32'd1, 4'hF, 4'd4, 32'd0, 1'b1, 1'b1);
    txn("and", 32'hF0, 32'h3C, OP_AND, 4'd5, 32'h30, 1'b0, 1'b0);

    // Back-to-back random stream at one command per cycle
    c0 = cyc;
    n0 = n_acc;
    for (int i = 0; i < 8; i++)
      send($urandom, $urandom_range(0, 40), 4'($urandom_range(0, 15)), 4'(i));
    bus.cmd_valid = 1'b0;
    check("stream_cycles", 64'(cyc - c0), 64'd8);
    check("stream_acc",    64'(n_acc - n0), 64'd8);
    drain();

    // Backpressure: only FIFO_DEPTH commands fit
    bus.rsp_ready = 1'b0;
    n0 = n_acc;
    for (int i = 0; i < 4; i++) send(32'(i + 1), 32'(i), OP_ADD, 4'(i));
    drive(32'd10, 32'd4, OP_ADD, 4'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready_low", 64'(bus.cmd_ready), 64'd0);
    end
    @(posedge clk); #1;
    check("bp_accepted", 64'(n_acc - n0), 64'd4);
    bus.rsp_ready = 1'b1;
    wait_accept();
    send(32'd11, 32'd5, OP_ADD, 4'd5);
    bus.cmd_valid = 1'b0;
    drain();

    // Async reset with 3 buffered responses and S1 busy
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'(i + 20), 32'd1, OP_OR, 4'(8 + i));
    bus.cmd_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("arst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("arst_alu_a",     64'(bus.alu_a),     64'd0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("arst_no_stale", 64'(bus.rsp_valid), 64'd0);

    // Statistics: 10 responses, 4 of them zero
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0) send(32'(i), 32'(i), OP_SUB, 4'(i));
      else            send(32'(i + 1), 32'd1, OP_ADD, 4'(i));
    end
    bus.cmd_valid = 1'b0;
    drain();
`ifdef ALU_CMD_SEQ_STATS_EN
    check("stat_done", 64'(bus.stat_done), 64'd10);
    check("stat_zero", 64'(bus.stat_zero), 64'd4);
`else
    check("stat_done", 64'(bus.stat_done), 64'd0);
    check("stat_zero", 64'(bus.stat_zero), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Pipelined issue/collect stage wrapped around the combinational 32-bit ALU.
- Accepts ALU commands over a valid/ready interface and registers the operands onto the ALU inputs.
- Captures the ALU result and zero flag one cycle later into an output FIFO.
- Returns tagged responses over a second valid/ready interface.
- Sustains one command per cycle with in-order responses.

Parameters:
- TAG_W, 4, width of the command/response tag.
- FIFO_DEPTH, 4, response FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  stage can accept a command this cycle.
- cmd_a  in  32  operand A.
- cmd_b  in  32  operand B.
- cmd_op  in  4  opcode (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL).
- cmd_tag  in  TAG_W  opaque tag, returned unchanged with the response.
- alu_a  out  32  registered operand A driven to the ALU.
- alu_b  out  32  registered operand B driven to the ALU.
- alu_op  out  4  registered opcode driven to the ALU.
- alu_result  in  32  ALU result, combinational from alu_a/alu_b/alu_op.
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  response available at the FIFO head.
- rsp_ready  in  1  consumer takes the response.
- rsp_result  out  32  result at the FIFO head.
- rsp_zero  out  1  zero flag at the FIFO head.
- rsp_illegal  out  1  head command had an opcode > 6.
- rsp_tag  out  TAG_W  tag at the FIFO head.
- stat_done  out  32  completed-response counter (see Optional Feature).
- stat_zero  out  32  zero-result counter (see Optional Feature).

Behaviour:
- Reset: all of the following go to 0 immediately, independent of clk: s1_valid, FIFO pointers and count, alu_a, alu_b, alu_op, all rsp_* outputs, stats.
- Reset mid-operation discards in-flight and buffered commands; nothing is replayed.
- Accept: a command is taken on a clock edge when cmd_valid && cmd_ready.
  - On accept, cmd_a/b/op load into alu_a/b/op, and tag plus illegal bit (cmd_op > 4'd6) load into the S1 register.
  - s1_valid is set.
- Capture: on each edge where s1_valid=1, {alu_result, alu_zero, s1_illegal, s1_tag} is pushed into the FIFO.
  - s1_valid then reflects whether a new command was accepted on that same edge.
- Latency: a command accepted at edge E0 is visible on rsp_* with rsp_valid=1 after edge E1 if the FIFO was empty (2-cycle latency). Throughput is 1 per cycle.
- Credit rule: cmd_ready = (fifo_count + s1_valid) < FIFO_DEPTH.
  - Computed from registers only; no combinational path from rsp_ready or cmd_valid.
  - S1 is therefore guaranteed a free FIFO slot and never stalls.
- Pop: on an edge with rsp_valid && rsp_ready, the head is removed.
  - Simultaneous push and pop leaves the count unchanged.
  - A push and pop in the same edge on a full FIFO is legal.
- Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. Count width is log2(FIFO_DEPTH)+1.
- rsp_* are driven from the FIFO head register; their values are don't-care when rsp_valid=0.
- When S1 is idle, alu_a/b/op hold the last accepted values (no toggling).
- Illegal opcode: the ALU yields result 0, zero 1; the response carries rsp_illegal=1 and is otherwise passed through.
- Responses are returned strictly in acceptance order.

Optional Feature:
- Macro: ALU_CMD_SEQ_STATS_EN.
- Defined:
  - stat_done increments by 1 on every response pop.
  - stat_zero increments on pops whose rsp_zero=1.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
  - Both reset to 0.
- Undefined: stat_done and stat_zero are tied to 0 and no counter flops exist.

Decomposition:
- Package alu_seq_pkg:
  - opcode localparams OP_ADD..OP_SRL;
  - OP_MAX_LEGAL = 4'd6;
  - response entry packing widths (32+1+1+TAG_W).
- Sub-module alu_seq_fifo: parameterised synchronous FIFO (WIDTH, DEPTH) with async active-high reset, push/pop/full/empty/count.

Test Plan:
- ADD: a=5, b=7, op=0, tag=3, rsp_ready=1 -> 2 cycles later rsp_valid=1, rsp_result=12, zero=0, illegal=0, tag=3.
- SUB: a=9, b=9, op=1 -> rsp_result=0, rsp_zero=1. SRL a=0x80000000, b=31, op=6 -> result=1.
- Backpressure: rsp_ready=0, stream 6 ADDs with tags 0..5 -> exactly 4 accepted, cmd_ready=0 from the next cycle. Then rsp_ready=1 -> tags 0,1,2,3 in order, after which tags 4 and 5 are accepted.
- Illegal: op=4'hF, a=1, b=1 -> result=0, zero=1, illegal=1. Following legal op=2 (0xF0 & 0x3C) -> 0x30, illegal=0.
- Reset: assert rst asynchronously with 3 responses buffered and S1 valid -> rsp_valid=0 and cmd_ready=1 immediately; no stale responses after release.
- With ALU_CMD_SEQ_STATS_EN: 10 responses, 4 with zero result -> stat_done=10, stat_zero=4. Without the macro -> both 0.
